// File: rtl/cpu.sv
// cpu: 4-bit accumulator executing one LOAD/ADD/SUB/AND per enable rising edge,
// with a 3-digit multiplexed active-low 7-segment display of ACC, OPD and OP.
module cpu #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clock,
    input  logic       enabling,
    input  logic       SW7,
    input  logic       SW6,
    input  logic       SW5,
    input  logic       SW4,
    input  logic       operation_bit1,
    input  logic       operation_bit0,
    input  logic       enable,
    output logic [3:0] rezult,
    output logic       carry,
    output logic       z,
    output logic       AN0,
    output logic       AN1,
    output logic       AN2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       fp,
    output logic       g,
    output logic       dp
);
    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [3:0]              acc_q, acc_d, opd, nib;
    logic                    carry_q, carry_d, enq_q, fire;
    logic [1:0]              op, di_q, di_d;
    logic [4:0]              sum, diff;
    logic [REFRESH_BITS-1:0] presc_q, presc_d;

    always_comb begin
        opd     = {SW7, SW6, SW5, SW4};
        op      = {operation_bit1, operation_bit0};
        fire    = enable && !enq_q && !enabling;
        sum     = {1'b0, acc_q} + {1'b0, opd};
        diff    = {1'b0, acc_q} - {1'b0, opd};
        acc_d   = !fire ? acc_q : op == 2'd0 ? opd : op == 2'd1 ? sum[3:0] :
                  op == 2'd2 ? diff[3:0] : acc_q & opd;
        carry_d = !fire ? carry_q : op == 2'd1 ? sum[4] : op == 2'd2 ? diff[4] : 1'b0;
        presc_d = presc_q + 1'b1;
        // DI skips 3: 0 -> 1 -> 2 -> 0 on each prescaler wrap
        di_d    = !(&presc_q) ? di_q : di_q == 2'd2 ? 2'd0 : di_q + 2'd1;
        nib     = di_q == 2'd0 ? acc_q : di_q == 2'd1 ? opd : {2'b00, op};
        {a, b, c, d, e, fp, g} = SEG[nib];
        {AN2, AN1, AN0} = di_q == 2'd0 ? 3'b110 : di_q == 2'd1 ? 3'b101 : 3'b011;
        dp      = di_q == 2'd0 ? ~carry_q : 1'b1;
        rezult  = acc_q;
        carry   = carry_q;
        z       = acc_q == 4'd0;
    end

    // enq tracks enable even in reset so an edge seen during reset is consumed
    always_ff @(posedge clock) begin
        enq_q <= enable;
        if (enabling) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            presc_q <= '0;
            di_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            presc_q <= presc_d;
            di_q    <= di_d;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table-driven ALU vectors with a scoreboard queue, plus hand-written
// sequences for reset, held enable, display multiplexing and reset/edge collision.
module tb_cpu;
    logic clock = 0, enabling = 1, enable = 0;
    logic SW7 = 0, SW6 = 0, SW5 = 0, SW4 = 0, operation_bit1 = 0, operation_bit0 = 0;
    logic [3:0] rezult;
    logic carry, z, AN0, AN1, AN2, a, b, c, d, e, fp, g, dp;
    int errors = 0, checks = 0;

    typedef struct {logic [1:0] op; logic [3:0] opd; logic [3:0] acc; logic cy;} vec_t;
    typedef struct {logic [3:0] acc; logic cy; logic zf;} exp_t;
    exp_t sb[$];
    vec_t vecs[12];
    logic [2:0] an_pat[3];
    logic [6:0] seg_pat[3];

    cpu #(.REFRESH_BITS(2)) dut (
        .clock(clock), .enabling(enabling), .SW7(SW7), .SW6(SW6), .SW5(SW5), .SW4(SW4),
        .operation_bit1(operation_bit1), .operation_bit0(operation_bit0), .enable(enable),
        .rezult(rezult), .carry(carry), .z(z), .AN0(AN0), .AN1(AN1), .AN2(AN2),
        .a(a), .b(b), .c(c), .d(d), .e(e), .fp(fp), .g(g), .dp(dp)
    );

    always #5 clock = ~clock;

    wire [6:0] seg = {a, b, c, d, e, fp, g};
    wire [2:0] an  = {AN2, AN1, AN0};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] opd);
        {operation_bit1, operation_bit0} = op;
        {SW7, SW6, SW5, SW4} = opd;
    endtask

    task automatic compare_head(input string name);
        exp_t x;
        x = sb.pop_front();
        check({name, ".rezult"}, {4'd0, rezult}, {4'd0, x.acc});
        check({name, ".carry"}, {7'd0, carry}, {7'd0, x.cy});
        check({name, ".z"}, {7'd0, z}, {7'd0, x.zf});
    endtask

    task automatic fire_op(input string name, input logic [1:0] op, input logic [3:0] opd,
                           input logic [3:0] acc, input logic cy);
        @(negedge clock);
        drive(op, opd);
        enable = 1;
        sb.push_back('{acc, cy, acc == 4'd0});
        @(negedge clock);
        enable = 0;
        compare_head(name);
    endtask

    task automatic wait_digit(input int idx);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (an === an_pat[idx]) return;
        end
        check("wait_digit", 8'd0, 8'd1);
    endtask

    initial begin
        an_pat  = '{3'b110, 3'b101, 3'b011};
        seg_pat = '{7'b0000000, 7'b0001000, 7'b0000110};
        vecs = '{
            '{2'd0, 4'd9,  4'd9,  1'b0}, '{2'd1, 4'd9,  4'd2,  1'b1},
            '{2'd0, 4'd3,  4'd3,  1'b0}, '{2'd2, 4'd5,  4'he,  1'b1},
            '{2'd2, 4'd14, 4'd0,  1'b0}, '{2'd0, 4'd12, 4'hc,  1'b0},
            '{2'd3, 4'd10, 4'd8,  1'b0}, '{2'd1, 4'd15, 4'd7,  1'b1},
            '{2'd2, 4'd0,  4'd7,  1'b0}, '{2'd3, 4'd0,  4'd0,  1'b0},
            '{2'd0, 4'd15, 4'hf,  1'b0}, '{2'd1, 4'd1,  4'd0,  1'b1}
        };

        repeat (2) @(negedge clock);
        enabling = 0;
        check("rst.rezult", {4'd0, rezult}, 8'd0);
        check("rst.carry", {7'd0, carry}, 8'd0);
        check("rst.z", {7'd0, z}, 8'd1);
        check("rst.an", {5'd0, an}, 8'b110);
        check("rst.seg", {1'b0, seg}, 8'b0000001);
        check("rst.dp", {7'd0, dp}, 8'd1);

        foreach (vecs[i]) fire_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].opd, vecs[i].acc, vecs[i].cy);

        // operands changing without an enable edge leave ACC alone
        @(negedge clock);
        drive(2'd0, 4'd7);
        repeat (3) @(negedge clock);
        check("idle.rezult", {4'd0, rezult}, 8'd0);
        check("idle.carry", {7'd0, carry}, 8'd1);

        fire_op("load9", 2'd0, 4'd9, 4'd9, 1'b0);
        fire_op("add9", 2'd1, 4'd9, 4'd2, 1'b1);
        wait_digit(0);
        check("dp.di0", {7'd0, dp}, 8'd0);
        wait_digit(1);
        check("dp.di1", {7'd0, dp}, 8'd1);

        fire_op("load12", 2'd0, 4'd12, 4'hc, 1'b0);
        fire_op("and10", 2'd3, 4'd10, 4'd8, 1'b0);
        wait_digit(2);
        wait_digit(0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("disp%0d.an", k), {5'd0, an}, {5'd0, an_pat[k / 4]});
            check($sformatf("disp%0d.seg", k), {1'b0, seg}, {1'b0, seg_pat[k / 4]});
            check($sformatf("disp%0d.dp", k), {7'd0, dp}, 8'd1);
            @(negedge clock);
        end

        fire_op("load1", 2'd0, 4'd1, 4'd1, 1'b0);
        @(negedge clock);
        drive(2'd1, 4'd1);
        enable = 1;
        sb.push_back('{4'd2, 1'b0, 1'b0});
        repeat (10) @(negedge clock);
        compare_head("hold");
        enable = 0;
        @(negedge clock);
        enable = 1;
        sb.push_back('{4'd3, 1'b0, 1'b0});
        @(negedge clock);
        compare_head("rearm");
        enable = 0;

        @(negedge clock);
        enabling = 1;
        enable = 1;
        drive(2'd0, 4'd5);
        @(negedge clock);
        enabling = 0;
        check("coll.rst", {4'd0, rezult}, 8'd0);
        repeat (3) @(negedge clock);
        check("coll.rezult", {4'd0, rezult}, 8'd0);
        check("coll.carry", {7'd0, carry}, 8'd0);
        check("coll.z", {7'd0, z}, 8'd1);
        enable = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: CPU

Interface
REQ-001 Parameter REFRESH_BITS, default 17: width of the display prescaler; each digit is shown for 2^REFRESH_BITS clocks.
REQ-002 One clock, reset synchronous active-high; all state changes on the rising edge of clock.
REQ-003 clock  input  1  system clock.
REQ-004 enabling  input  1  synchronous active-high reset.
REQ-005 SW7,SW6,SW5,SW4  input  1 each  operand nibble OPD = {SW7,SW6,SW5,SW4}, SW7 is the MSB.
REQ-006 operation_bit1,operation_bit0  input  1 each  opcode OP = {operation_bit1,operation_bit0}.
REQ-007 enable  input  1  execute request; its rising edge triggers exactly one operation.
REQ-008 rezult  output  4  accumulator ACC.
REQ-009 carry  output  1  registered carry/borrow flag.
REQ-010 z  output  1  zero flag, combinational: 1 when rezult==0.
REQ-011 AN0,AN1,AN2  output  1 each  7-segment digit anodes, active-low.
REQ-012 a,b,c,d,e,fp,g  output  1 each  segments a..g (fp = segment f), active-low.
REQ-013 dp  output  1  decimal point, active-low.

Function
REQ-014 Edge detect: register enq samples enable on every clock, including during reset; an operation fires on a clock edge where enable==1, enq==0 and enabling==0.
REQ-015 Latency: ACC and carry take their new values on the same edge where the operation fires; z follows combinationally.
REQ-016 OP=00 LOAD: ACC<=OPD, carry<=0.
REQ-017 OP=01 ADD: {carry,ACC}<=ACC+OPD as a 5-bit sum; wraps modulo 16 with carry=1 on overflow.
REQ-018 OP=10 SUB: ACC<=(ACC-OPD) mod 16, carry<=1 iff ACC<OPD (borrow).
REQ-019 OP=11 AND: ACC<=ACC&OPD, carry<=0.
REQ-020 When enable is held high, only one operation fires; another requires enable to go low for at least one clock, then high again.
REQ-021 OP and OPD are sampled on the firing edge only; changes at other times do not affect ACC.
REQ-022 Prescaler: counts 0..2^REFRESH_BITS-1 and wraps. On each wrap the digit index DI advances 0->1->2->0. Value 3 never occurs.
REQ-023 DI=0: AN0=0, displays ACC in hex, dp=~carry.
REQ-024 DI=1: AN1=0, displays the live OPD in hex, dp=1.
REQ-025 DI=2: AN2=0, displays OP as hex 0..3, dp=1.
REQ-026 Exactly one anode is low at any time; anodes and segments are registered or driven glitch-free from DI.
REQ-027 Hex decoder uses the standard active-low patterns, listed as {a,b,c,d,e,fp,g}:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000

Reset
REQ-028 While enabling==1 at a clock edge:
- ACC<=0, carry<=0, prescaler<=0, DI<=0.
- No operation fires, even on an enable edge.
REQ-029 Post-reset outputs:
- rezult=0000, carry=0, z=1.
- AN0=0, AN1=1, AN2=1.
- Segments show "0" (abcdefp=0, g=1), dp=1.
REQ-030 Reset asserted in the same cycle as an enable rising edge: reset wins, and the edge is consumed (enq tracks enable), so no operation fires after release.

Verification (REFRESH_BITS=2 for simulation)
REQ-031 Reset for 2 clocks -> rezult=0, carry=0, z=1, AN0/AN1/AN2=0/1/1, segments "0", dp=1.
REQ-032 LOAD 9 (OP=00, SW=1001, enable pulse) -> rezult=1001, carry=0, z=0; then ADD 9 -> rezult=0010, carry=1; during DI=0, dp=0.
REQ-033 LOAD 3, then SUB 5 -> rezult=1110, carry=1; then SUB 14 -> rezult=0000, carry=0, z=1.
REQ-034 LOAD 1, then enable held high 10 clocks with OP=01, SW=0001 -> rezult=0010 (single ADD); drop enable, raise it again -> rezult=0011.
REQ-035 LOAD 12, then AND 10 -> rezult=1000, carry=0; display over 12 clocks cycles AN0,AN1,AN2 every 4 clocks showing 8, A, 3.
REQ-036 Enable edge coincident with enabling=1, released with enable still high -> rezult stays 0, no operation fires.
